sequential_divider: RTL

- Iterative radix-2 restoring divider; the inverse-operation companion to the datapath's sequential multiplier.
- Uses the same op_start / op_clear / op_done handshake, so the controller drives both blocks identically.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Returns both halves packed into a 2*WIDTH result bus.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 43 ++++
 rtl/my_cla8.sv | 30 +++
 rtl/sequential_divider.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default width, counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 64;
    localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT) + 1;

    function automatic int div_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    localparam int NGRP = (WIDTH + 8) / 8;
    localparam int NB   = NGRP * 8;

    logic [NB-1:0] w_a;
    logic [NB-1:0] w_b;
    logic [NB-1:0] w_sum;
    logic [NGRP:0] w_carry;
    logic          w_nonneg;

    assign w_a        = NB'({i_rem, i_bit});
    assign w_b        = ~(NB'(i_divisor));
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < NGRP; g++) begin : g_cla
        my_cla8 u_cla (
            .i_a    (w_a[8*g +: 8]),
            .i_b    (w_b[8*g +: 8]),
            .i_cin  (w_carry[g]),
            .o_sum  (w_sum[8*g +: 8]),
            .o_cout (w_carry[g + 1])
        );
    end

    // No borrow means the trial is non-negative; a valid trial always fits below the divisor,
    // so any set bit above WIDTH is treated as a failed trial.
    assign w_nonneg = w_carry[NGRP] & ~(|w_sum[NB-1:WIDTH]);
    assign o_qbit   = w_nonneg;
    assign o_rem    = w_nonneg ? w_sum[WIDTH-1:0] : {i_rem[WIDTH-2:0], i_bit};

endmodule

// File: rtl/my_cla8.sv
// 8-bit carry-lookahead adder slice; every carry is formed directly from the slice inputs.
module my_cla8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;

    // Generate/propagate terms and flattened lookahead carries
    always_comb begin
        w_g    = i_a & i_b;
        w_p    = i_a ^ i_b;
        w_c    = 9'd0;
        w_c[0] = i_cin;
        for (int i = 0; i < 8; i++) begin
            w_c[i + 1] = i_cin;
            for (int j = 0; j <= i; j++) begin
                w_c[i + 1] = w_g[j] | (w_p[j] & w_c[i + 1]);
            end
        end
        o_sum  = w_p ^ w_c[7:0];
        o_cout = w_c[8];
    end

endmodule

// File: rtl/sequential_divider.sv
// Iterative radix-2 restoring divider with op_start/op_clear/op_done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module sequential_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               op_done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int               CNT_W    = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    div_state_t         r_state;
    div_state_t         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [2*WIDTH-1:0] r_result;
    logic               r_done;
    logic               r_dbz;
    logic [2*WIDTH-1:0] w_result_next;
    logic               w_done_next;
    logic               w_dbz_next;
    logic [WIDTH-1:0]   w_dd_mag;
    logic [WIDTH-1:0]   w_dv_mag;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_qbit;
    logic [WIDTH-1:0]   w_quo_raw;
    logic [WIDTH-1:0]   w_quo_final;
    logic [WIDTH-1:0]   w_rem_final;
    logic               w_div_zero;
    logic               w_last;

    assign w_div_zero = (divisor == ZERO_W);
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_quo_raw  = {r_quo[WIDTH-2:0], w_step_qbit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic r_neg_q;
    logic r_neg_r;

    assign w_dd_mag    = dividend[WIDTH-1] ? (~dividend + ONE_W) : dividend;
    assign w_dv_mag    = divisor[WIDTH-1]  ? (~divisor + ONE_W)  : divisor;
    assign w_quo_final = r_neg_q ? (~w_quo_raw + ONE_W) : w_quo_raw;
    assign w_rem_final = r_neg_r ? (~w_step_rem + ONE_W) : w_step_rem;

    // Result signs captured with the operands on the accepted-start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (op_clear) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && op_start) begin
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
        end else begin
            r_neg_q <= r_neg_q;
            r_neg_r <= r_neg_r;
        end
    end
`else
    assign w_dd_mag    = dividend;
    assign w_dv_mag    = divisor;
    assign w_quo_final = w_quo_raw;
    assign w_rem_final = w_step_rem;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; op_clear dominates everything
    always_comb begin
        w_state_next = r_state;
        if (op_clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_start) begin
                        w_state_next = w_div_zero ? DONE : BUSY;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                BUSY: begin
                    if (w_last) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = BUSY;
                    end
                end
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered result and flags
    always_comb begin
        w_result_next = r_result;
        w_dbz_next    = r_dbz;
        w_done_next   = (w_state_next == DONE);
        if (op_clear) begin
            w_result_next = {2*WIDTH{1'b0}};
            w_dbz_next    = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_start && w_div_zero) begin
                        w_result_next = {dividend, ALL_ONES};
                        w_dbz_next    = 1'b1;
                    end else begin
                        w_result_next = r_result;
                        w_dbz_next    = r_dbz;
                    end
                end
                BUSY: begin
                    if (w_last) begin
                        w_result_next = {w_rem_final, w_quo_final};
                        w_dbz_next    = 1'b0;
                    end else begin
                        w_result_next = r_result;
                        w_dbz_next    = r_dbz;
                    end
                end
                DONE: begin
                    w_result_next = r_result;
                    w_dbz_next    = r_dbz;
                end
                default: begin
                    w_result_next = {2*WIDTH{1'b0}};
                    w_dbz_next    = 1'b0;
                end
            endcase
        end
    end

    // Iteration datapath: partial remainder, dividend/quotient shifter, divisor, step counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem <= ZERO_W;
            r_quo <= ZERO_W;
            r_div <= ZERO_W;
            r_cnt <= {CNT_W{1'b0}};
        end else if (op_clear) begin
            r_rem <= ZERO_W;
            r_quo <= ZERO_W;
            r_div <= ZERO_W;
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_start) begin
                        r_rem <= ZERO_W;
                        r_quo <= w_dd_mag;
                        r_div <= w_dv_mag;
                        r_cnt <= {CNT_W{1'b0}};
                    end else begin
                        r_rem <= r_rem;
                        r_quo <= r_quo;
                        r_div <= r_div;
                        r_cnt <= r_cnt;
                    end
                end
                BUSY: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_quo_raw;
                    r_div <= r_div;
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    r_rem <= r_rem;
                    r_quo <= r_quo;
                    r_div <= r_div;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= {2*WIDTH{1'b0}};
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_result <= w_result_next;
            r_done   <= w_done_next;
            r_dbz    <= w_dbz_next;
        end
    end

    assign op_done     = r_done;
    assign div_by_zero = r_dbz;
    assign result      = r_result;

endmodule
